// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: drives one-hot column strobes into an 8x8 key matrix,
// samples the synchronized row returns once per column dwell, debounces whole
// scan results and reports single-key presses through a valid/ack handshake.
// Multi-key state and lost presses (overrun) are flagged alongside.
module matrix_key_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_row,
  output logic [7:0] key_col,
  output logic [5:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       multi_key,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  // Scan results are carried as a saturating key count (0 none, 1 single,
  // 2 multi) plus the code of the first pressed key found.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } hs_state_t;

  logic [7:0]    row_meta_r;
  logic [7:0]    row_sync_r;
  logic [2:0]    col_idx_r;
  logic [DW-1:0] dwell_r;
  logic [7:0]    key_col_r;
  logic [1:0]    acc_cnt_r;
  logic [5:0]    acc_code_r;
  logic [1:0]    prev_cnt_r;
  logic [5:0]    prev_code_r;
  logic [SW-1:0] stable_cnt_r;
  logic [1:0]    accepted_cnt_r;
  logic [5:0]    accepted_code_r;
  logic          key_held_r;
  logic          multi_key_r;
  hs_state_t     state_r;
  logic [5:0]    key_code_r;
  logic          key_valid_r;
  logic          overrun_r;

  logic          sample_s;
  logic          scan_done_s;
  logic [2:0]    next_idx_s;
  logic [1:0]    col_cnt_s;
  logic [2:0]    col_row_s;
  logic [2:0]    sum_s;
  logic [1:0]    scan_cnt_s;
  logic [5:0]    scan_code_s;
  logic          same_s;
  logic          differs_s;
  logic [SW-1:0] stable_next_s;
  logic          accept_s;
  logic          press_s;

  assign sample_s    = (dwell_r == DWELL_LAST);
  assign scan_done_s = sample_s && (col_idx_r == 3'd7);
  assign next_idx_s  = col_idx_r + 3'd1;

  // Two-flop synchronizer for the asynchronous row return lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_r <= 8'h00;
      row_sync_r <= 8'h00;
    end else begin
      row_meta_r <= key_row;
      row_sync_r <= row_meta_r;
    end
  end

  // Column index / dwell counter and the registered one-hot column drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx_r <= 3'd0;
      dwell_r   <= '0;
      key_col_r <= 8'h80;
    end else if (sample_s) begin
      col_idx_r <= next_idx_s;
      dwell_r   <= '0;
      key_col_r <= 8'h80 >> next_idx_s;
    end else begin
      dwell_r   <= dwell_r + DW'(1);
    end
  end

  // Count pressed rows in the current column (saturating) and locate the
  // lowest-numbered one; row r arrives on bit 7-r.
  always_comb begin
    col_cnt_s = 2'd0;
    col_row_s = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (row_sync_r[3'(7 - r)]) begin
        col_row_s = 3'(r);
        col_cnt_s = (col_cnt_s == 2'd2) ? 2'd2 : col_cnt_s + 2'd1;
      end else begin
        col_row_s = col_row_s;
        col_cnt_s = col_cnt_s;
      end
    end
  end

  // Fold this column into the running scan result; at column 7 this is the
  // complete scan result.
  always_comb begin
    sum_s       = {1'b0, acc_cnt_r} + {1'b0, col_cnt_s};
    scan_cnt_s  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    if ((acc_cnt_r == 2'd0) && (col_cnt_s != 2'd0)) begin
      scan_code_s = {col_idx_r, col_row_s};
    end else begin
      scan_code_s = acc_code_r;
    end
  end

  // Per-scan accumulator: updated at each column sample, cleared when a scan
  // completes so the next scan starts empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 6'd0;
    end else if (scan_done_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 6'd0;
    end else if (sample_s) begin
      acc_cnt_r  <= scan_cnt_s;
      acc_code_r <= scan_code_s;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Debounce decisions: compare the finished scan with the previous one and
  // with the accepted state; the code only matters for single-key results.
  always_comb begin
    same_s    = (scan_cnt_s == prev_cnt_r) &&
                ((scan_cnt_s != 2'd1) || (scan_code_s == prev_code_r));
    differs_s = (scan_cnt_s != accepted_cnt_r) ||
                ((scan_cnt_s == 2'd1) && (scan_code_s != accepted_code_r));
    if (same_s) begin
      stable_next_s = (stable_cnt_r == STABLE_MAX) ? STABLE_MAX : stable_cnt_r + SW'(1);
    end else begin
      stable_next_s = SW'(1);
    end
    accept_s = scan_done_s && (stable_next_s == STABLE_MAX) && differs_s;
    press_s  = accept_s && (scan_cnt_s == 2'd1);
  end

  // Debounce history, accepted state and its registered decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt_r      <= 2'd0;
      prev_code_r     <= 6'd0;
      stable_cnt_r    <= '0;
      accepted_cnt_r  <= 2'd0;
      accepted_code_r <= 6'd0;
      key_held_r      <= 1'b0;
      multi_key_r     <= 1'b0;
    end else if (scan_done_s) begin
      stable_cnt_r <= stable_next_s;
      if (!same_s) begin
        prev_cnt_r  <= scan_cnt_s;
        prev_code_r <= scan_code_s;
      end
      if (accept_s) begin
        accepted_cnt_r  <= scan_cnt_s;
        accepted_code_r <= scan_code_s;
        key_held_r      <= (scan_cnt_s == 2'd1);
        multi_key_r     <= (scan_cnt_s == 2'd2);
      end
    end
  end

  // Handshake FSM: latch a press into key_code/key_valid, release on ack,
  // and flag a press that arrives while one is still pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      key_code_r  <= 6'd0;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (press_s) begin
            key_code_r  <= scan_code_s;
            key_valid_r <= 1'b1;
            state_r     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (key_ack) begin
            if (press_s) begin
              key_code_r <= scan_code_s;
            end else begin
              key_valid_r <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end else if (press_s) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          key_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign key_col   = key_col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;
  assign multi_key = multi_key_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Testbench for matrix_key_scanner: an 8x8 key matrix model driven from a
// 64-bit "keys down" mask (bit index = column*8 + row = key code), a
// scan-level reference model, a per-cycle compare process and directed steps.
module tb_matrix_key_scanner;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 8 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_row;
  logic [7:0]  key_col;
  logic [5:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_held;
  logic        multi_key;
  logic        overrun;

  logic [63:0] mask = 64'd0;
  logic [7:0]  col_one = 8'h80;
  logic        run_chk = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  // reference model state
  int          m_edges = 0;
  int          m_acc = -1;     // -1 none, -2 multi, else code of single key
  int          m_h0 = -1;
  int          m_h1 = -1;
  int          m_nh = 0;
  logic        m_valid = 1'b0;
  logic [5:0]  m_code = 6'd0;
  logic        m_over = 1'b0;

  matrix_key_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .multi_key (multi_key),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  // Physical matrix: the driven column connects its pressed keys to rows.
  always_comb begin
    key_row = 8'h00;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        key_row[3'(7 - r)] = key_row[3'(7 - r)] |
                             ((key_col == (col_one >> c)) & mask[6'(c * 8 + r)]);
      end
    end
  end

  // Whole-scan result from the set of keys down: none, multi, or the code
  // of the only key (the lowest set bit is the first key in scan order).
  function automatic int scan_result(input logic [63:0] m);
    int cnt;
    int first;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 64; i++) begin
      if (m[i]) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    if (cnt == 0) return -1;
    if (cnt == 1) return first;
    return -2;
  endfunction

  // Reference model: a scan completes every SCAN edges; a result seen on DB
  // consecutive scans that differs from the accepted one becomes accepted.
  initial begin
    int   r;
    logic ev;
    logic [5:0] ev_code;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_edges = 0; m_acc = -1; m_h0 = -1; m_h1 = -1; m_nh = 0;
        m_valid = 1'b0; m_code = 6'd0; m_over = 1'b0;
      end else begin
        ev = 1'b0;
        ev_code = 6'd0;
        m_edges++;
        if (m_edges % SCAN == 0) begin
          r = scan_result(mask);
          m_h0 = m_h1;
          m_h1 = r;
          if (m_nh < 2) m_nh++;
          if (m_nh == 2 && m_h0 == m_h1 && r != m_acc) begin
            m_acc = r;
            if (r >= 0) begin
              ev = 1'b1;
              ev_code = r[5:0];
            end
          end
        end
        if (!m_valid) begin
          if (ev) begin
            m_valid = 1'b1;
            m_code = ev_code;
          end
        end else if (key_ack) begin
          if (ev) m_code = ev_code;
          else m_valid = 1'b0;
        end else if (ev) begin
          m_over = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      check("cyc_key_col",   key_col, col_one >> ((m_edges / SD) % 8));
      check("cyc_key_code",  8'(key_code), 8'(m_code));
      check("cyc_key_valid", 8'(key_valid), 8'(m_valid));
      check("cyc_key_held",  8'(key_held), 8'(m_acc >= 0));
      check("cyc_multi_key", 8'(multi_key), 8'(m_acc == -2));
      check("cyc_overrun",   8'(overrun), 8'(m_over));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    step(1);
    while (m_edges % SCAN != 0) step(1);
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"},   key_col, 8'h80);
    check({tag, "_code"},  8'(key_code), 8'd0);
    check({tag, "_valid"}, 8'(key_valid), 8'd0);
    check({tag, "_held"},  8'(key_held), 8'd0);
    check({tag, "_multi"}, 8'(multi_key), 8'd0);
    check({tag, "_ovr"},   8'(overrun), 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    key_ack = 1'b0;
    mask = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    run_chk = 1'b1;
    check_reset_values("reset");
    step(1);
    reset = 1'b0;

    // 1: column stepping and wrap
    for (int i = 0; i <= 32; i++) begin
      check("scan_col", key_col, col_one >> ((i / 4) % 8));
      if (i != 32) step(1);
    end

    // 2: single press of code 21 (column 2, row 5), ack, release
    mask = 64'd1 << 21;
    step(63);
    check("press_early_valid", 8'(key_valid), 8'd0);
    step(1);
    check("press_valid", 8'(key_valid), 8'd1);
    check("press_code",  8'(key_code), 8'd21);
    check("press_held",  8'(key_held), 8'd1);
    check("model_code",  8'(m_code), 8'd21);
    pulse_ack();
    check("ack_valid", 8'(key_valid), 8'd0);
    check("ack_held",  8'(key_held), 8'd1);
    align();
    mask = 64'd0;
    step(63);
    check("rel_held_early", 8'(key_held), 8'd1);
    step(1);
    check("rel_held",  8'(key_held), 8'd0);
    check("rel_valid", 8'(key_valid), 8'd0);

    // 3: bounce on alternate scans
    for (int s = 0; s < 10; s++) begin
      mask = (s % 2 == 0) ? (64'd1 << 21) : 64'd0;
      step(SCAN);
    end
    check("bounce_valid", 8'(key_valid), 8'd0);
    check("bounce_held",  8'(key_held), 8'd0);
    check("bounce_multi", 8'(multi_key), 8'd0);

    // 4: two keys (codes 0 and 25), then release 25
    mask = (64'd1 << 0) | (64'd1 << 25);
    step(64);
    check("two_multi", 8'(multi_key), 8'd1);
    check("two_valid", 8'(key_valid), 8'd0);
    check("two_held",  8'(key_held), 8'd0);
    mask = 64'd1 << 0;
    step(64);
    check("one_multi", 8'(multi_key), 8'd0);
    check("one_held",  8'(key_held), 8'd1);
    check("one_valid", 8'(key_valid), 8'd1);
    check("one_code",  8'(key_code), 8'd0);
    pulse_ack();
    align();
    mask = 64'd0;
    step(SCAN - 1);
    step(64 - (SCAN - 1));

    // 5: overrun
    mask = 64'd1 << 21;
    step(64);
    check("ovr_first_valid", 8'(key_valid), 8'd1);
    check("ovr_first_code",  8'(key_code), 8'd21);
    mask = 64'd0;
    step(64);
    mask = 64'd1 << 9;
    step(64);
    check("ovr_flag",  8'(overrun), 8'd1);
    check("ovr_code",  8'(key_code), 8'd21);
    check("ovr_held",  8'(key_held), 8'd1);
    check("model_ovr", 8'(m_over), 8'd1);
    pulse_ack();
    check("ovr_ack_valid", 8'(key_valid), 8'd0);
    check("ovr_ack_flag",  8'(overrun), 8'd1);
    pulse_ack();
    check("idle_ack_valid", 8'(key_valid), 8'd0);

    // 6: reset while pending, mid-scan at column 4
    align();
    mask = 64'd1 << 21;
    step(64);
    check("pre_rst_valid", 8'(key_valid), 8'd1);
    step(17);
    check("pre_rst_col", key_col, 8'h08);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    step(3);
    reset = 1'b0;
    check("post_rst_col", key_col, 8'h80);
    step(63);
    check("rerep_early", 8'(key_valid), 8'd0);
    step(1);
    check("rerep_valid", 8'(key_valid), 8'd1);
    check("rerep_code",  8'(key_code), 8'd21);
    check("rerep_ovr",   8'(overrun), 8'd0);

    // ack on the same edge as a new press event
    mask = 64'd1 << 9;
    step(63);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    check("same_valid", 8'(key_valid), 8'd1);
    check("same_code",  8'(key_code), 8'd9);
    check("same_ovr",   8'(overrun), 8'd0);
    pulse_ack();
    check("final_valid", 8'(key_valid), 8'd0);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
